// File: rtl/keypad_scanner_deb.sv
// Matrix keypad scanner with debounce. Probes all rows while idle, locates the key
// row by row, then debounces the press and the release on scan_tick samples.
module keypad_scanner_deb #(
    parameter int NROWS       = 4,
    parameter int NCOLS       = 4,
    parameter int DEB_CNT     = 3,
    parameter int ACTIVE_HIGH = 1,
    localparam int KW  = ($clog2(NROWS*NCOLS) > 1) ? $clog2(NROWS*NCOLS) : 1,
    localparam int RW  = ($clog2(NROWS) > 1) ? $clog2(NROWS) : 1,
    localparam int CLW = ($clog2(NCOLS) > 1) ? $clog2(NCOLS) : 1,
    localparam int DW  = ($clog2(DEB_CNT) > 1) ? $clog2(DEB_CNT) : 1
) (
    input  logic             clk_sec,
    input  logic             rst_n,
    input  logic             scan_tick,
    input  logic [NCOLS-1:0] col_in,
    output logic [NROWS-1:0] row_out,
    output logic             key_valid,
    output logic [KW-1:0]    key_code,
    output logic             key_held
);

    typedef enum logic [1:0] {IDLE, SCAN, DEB, HELD} state_t;

    state_t           state, state_nx;
    logic [RW-1:0]    row_idx, row_idx_nx, cap_row, cap_row_nx;
    logic [CLW-1:0]   cap_col, cap_col_nx, win_col;
    logic [DW-1:0]    cnt, cnt_nx;
    logic             key_valid_nx, key_held_nx;
    logic [KW-1:0]    key_code_nx;
    logic [NCOLS-1:0] sync1, sync2, col_s;
    logic [NROWS-1:0] row_act;
    logic [RW-1:0]    row_sel;

    // Normalise before the first flop so a cleared synchroniser means "no key"
    // for either pin polarity.
    always_ff @(posedge clk_sec) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= (ACTIVE_HIGH != 0) ? col_in : ~col_in;
            sync2 <= sync1;
        end
    end
    assign col_s = sync2;

    always_comb begin
        win_col = '0;
        for (int c = NCOLS-1; c >= 0; c--)
            if (col_s[c]) win_col = CLW'(c);
    end

    // Row 0 drives the MSB of row_out.
    assign row_sel = (state == SCAN) ? row_idx : cap_row;
    always_comb begin
        row_act = '0;
        if (state == IDLE)
            row_act = '1;
        else
            for (int r = 0; r < NROWS; r++)
                row_act[NROWS-1-r] = (row_sel == RW'(r));
    end
    assign row_out = (ACTIVE_HIGH != 0) ? row_act : ~row_act;

    always_ff @(posedge clk_sec) begin
        if (!rst_n) begin
            state     <= IDLE;
            row_idx   <= '0;
            cap_row   <= '0;
            cap_col   <= '0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nx;
            row_idx   <= row_idx_nx;
            cap_row   <= cap_row_nx;
            cap_col   <= cap_col_nx;
            cnt       <= cnt_nx;
            key_valid <= key_valid_nx;
            key_code  <= key_code_nx;
            key_held  <= key_held_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        row_idx_nx   = row_idx;
        cap_row_nx   = cap_row;
        cap_col_nx   = cap_col;
        cnt_nx       = cnt;
        key_valid_nx = 1'b0;
        key_code_nx  = key_code;
        key_held_nx  = key_held;
        if (scan_tick) begin
            unique case (state)
                IDLE: begin
                    if (col_s != '0) begin
                        state_nx   = SCAN;
                        row_idx_nx = '0;
                    end
                end
                SCAN: begin
                    if (col_s != '0) begin
                        cap_row_nx = row_idx;
                        cap_col_nx = win_col;
                        cnt_nx     = DW'(1);
                        state_nx   = DEB;
                    end else if (row_idx == RW'(NROWS-1)) begin
                        row_idx_nx = '0;
                        state_nx   = IDLE;
                    end else begin
                        row_idx_nx = row_idx + 1'b1;
                    end
                end
                DEB: begin
                    if (!col_s[cap_col]) begin
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else if (cnt == DW'(DEB_CNT-1)) begin
                        key_valid_nx = 1'b1;
                        key_held_nx  = 1'b1;
                        key_code_nx  = KW'(cap_row) * KW'(NCOLS) + KW'(cap_col);
                        cnt_nx       = '0;
                        state_nx     = HELD;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                HELD: begin
                    // cnt counts consecutive released samples here
                    if (col_s[cap_col]) begin
                        cnt_nx = '0;
                    end else if (cnt == DW'(DEB_CNT-1)) begin
                        key_held_nx = 1'b0;
                        cnt_nx      = '0;
                        state_nx    = IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner_deb.sv
// Bench for keypad_scanner_deb: keypad matrix model, code scoreboard, press table
// plus hand sequences for bounce, release glitch and reset mid-debounce.
module tb_keypad_scanner_deb;
    localparam int NR = 4;
    localparam int NC = 4;

    logic          clk_sec = 1'b0;
    logic          rst_n, scan_tick;
    logic [NC-1:0] col_in, col_in_n;
    logic [NR-1:0] row_out, row_out_n;
    logic          key_valid, key_valid_n, key_held, key_held_n;
    logic [3:0]    key_code, key_code_n;
    logic [NR-1:0][NC-1:0] kp;

    int n_cmp = 0, n_bad = 0, n_valid = 0;
    logic [3:0] exp_q[$];
    logic prev_v = 1'b0;

    always #5 clk_sec = ~clk_sec;

    keypad_scanner_deb #(.NROWS(NR), .NCOLS(NC), .DEB_CNT(3), .ACTIVE_HIGH(1)) dut (
        .clk_sec(clk_sec), .rst_n(rst_n), .scan_tick(scan_tick), .col_in(col_in),
        .row_out(row_out), .key_valid(key_valid), .key_code(key_code), .key_held(key_held));

    keypad_scanner_deb #(.NROWS(NR), .NCOLS(NC), .DEB_CNT(3), .ACTIVE_HIGH(0)) dut_n (
        .clk_sec(clk_sec), .rst_n(rst_n), .scan_tick(scan_tick), .col_in(col_in_n),
        .row_out(row_out_n), .key_valid(key_valid_n), .key_code(key_code_n), .key_held(key_held_n));

    // Keypad: a pressed key connects its row line to its column line.
    always_comb begin
        col_in   = '0;
        col_in_n = '1;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                if (kp[r][c] && row_out[NR-1-r])    col_in[c]   = 1'b1;
                if (kp[r][c] && !row_out_n[NR-1-r]) col_in_n[c] = 1'b0;
            end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk_sec) begin
        if (key_valid) begin
            n_valid++;
            check("sb_expect_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("sb_key_code", key_code, exp_q.pop_front());
        end
        if (key_valid && prev_v) check("valid_one_cycle", 0, 1);
        prev_v = key_valid;
    end

    task automatic tick();
        repeat (3) @(posedge clk_sec);
        #1 scan_tick = 1'b1;
        @(posedge clk_sec);
        #1 scan_tick = 1'b0;
    endtask

    typedef struct {
        int r0, c0, r1, c1;
        logic [3:0] code;
        int loc_row;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int nv;
        logic [3:0] oh;
        vecs[0] = '{2, 1, -1, -1, 4'd9, 2};
        vecs[1] = '{0, 0, -1, -1, 4'd0, 0};
        vecs[2] = '{3, 3, -1, -1, 4'd15, 3};
        vecs[3] = '{3, 0, 3, 3, 4'd12, 3};
        vecs[4] = '{1, 2, 3, 2, 4'd6, 1};
        vecs[5] = '{0, 3, 2, 0, 4'd3, 0};

        rst_n = 1'b0; scan_tick = 1'b0; kp = '0;
        repeat (2) @(posedge clk_sec);
        #1;
        check("rst_row_out", row_out, 4'b1111);
        check("rst_row_out_n", row_out_n, 4'b0000);
        check("rst_key_held", key_held, 0);
        check("rst_key_code", key_code, 0);
        rst_n = 1'b1;

        // Clean press (2,1) with row walk, then release with one glitch
        kp[2][1] = 1'b1;
        exp_q.push_back(4'd9);
        check("idle_rows", row_out, 4'b1111);
        tick(); check("scan_r0", row_out, 4'b1000);
        tick(); check("scan_r1", row_out, 4'b0100);
        tick(); check("scan_r2", row_out, 4'b0010);
        tick(); check("deb_row", row_out, 4'b0010);
        tick(); check("no_early_valid", n_valid, 0);
        tick(); @(negedge clk_sec); #1;
        check("valid_count", n_valid, 1);
        check("held_after_press", key_held, 1);
        check("held_row", row_out, 4'b0010);
        check("code_n", key_code_n, 9);
        check("held_n", key_held_n, 1);
        kp = '0;       tick();
        kp[2][1] = 1'b1; tick();
        kp = '0;       tick(); tick();
        check("held_before_rel", key_held, 1);
        tick();
        check("released", key_held, 0);
        check("rel_idle_rows", row_out, 4'b1111);

        // Press table: latency from first idle sample, code, held row
        for (int i = 0; i < 6; i++) begin
            kp = '0;
            kp[vecs[i].r0][vecs[i].c0] = 1'b1;
            if (vecs[i].r1 >= 0) kp[vecs[i].r1][vecs[i].c1] = 1'b1;
            exp_q.push_back(vecs[i].code);
            nv = n_valid;
            repeat (vecs[i].loc_row + 3) tick();
            check("tbl_no_early", n_valid, nv);
            tick(); @(negedge clk_sec); #1;
            check("tbl_valid_count", n_valid, nv + 1);
            check("tbl_code", key_code, vecs[i].code);
            check("tbl_held", key_held, 1);
            oh = 4'b1000 >> vecs[i].loc_row;
            check("tbl_row", row_out, oh);
            kp = '0;
            repeat (3) tick();
            check("tbl_released", key_held, 0);
        end

        // Bounce: (1,3) captured, one more match, then gone
        nv = n_valid;
        kp[1][3] = 1'b1;
        repeat (4) tick();
        kp = '0;
        tick();
        check("bounce_idle", row_out, 4'b1111);
        repeat (3) tick();
        check("bounce_no_valid", n_valid, nv);
        check("bounce_code_kept", key_code, 3);

        // Reset while debouncing with cnt=2
        kp[1][3] = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        @(posedge clk_sec); #1;
        check("rdeb_row_out", row_out, 4'b1111);
        check("rdeb_code", key_code, 0);
        check("rdeb_held", key_held, 0);
        check("rdeb_valid", key_valid, 0);
        kp = '0;
        @(posedge clk_sec); #1;
        rst_n = 1'b1;
        repeat (6) tick();
        check("rdeb_no_valid", n_valid, nv);
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
